// File: rtl/kmp_ff_gen.sv
// KMP failure-function generator.
// Builds ff[i] (longest proper prefix of pat[0..i] that is also a suffix)
// one comparison step per clock, then presents the table on ff_result
// under a level input_valid/output_valid handshake.
module kmp_ff_gen #(
   parameter int BYTE        = 8,
   parameter int MAX_PATTERN = 8,
   parameter int MAX_PAT_ADD = 3
) (
   input  logic                             clk,
   input  logic                             reset,
   input  logic [MAX_PATTERN*BYTE-1:0]      pat_input,
   input  logic [MAX_PAT_ADD-1:0]           pat_last_idx,
   input  logic                             input_valid,
   output logic                             busy,
   output logic                             output_valid,
   output logic [MAX_PAT_ADD*MAX_PATTERN-1:0] ff_result
);

   typedef enum logic [1:0] {
      IDLE,
      INIT,
      COMP,
      DONE
   } state_t;

   state_t                            state_q, state_d;
   logic [MAX_PATTERN*BYTE-1:0]       pat_q, pat_d;
   logic [MAX_PAT_ADD-1:0]            last_q, last_d;
   logic [MAX_PAT_ADD:0]              i_q, i_d;
   logic [MAX_PAT_ADD-1:0]            len_q, len_d;
   logic [MAX_PAT_ADD*MAX_PATTERN-1:0] ff_q, ff_d;

   logic [MAX_PAT_ADD-1:0]            iIdx;
   logic [MAX_PAT_ADD-1:0]            prevLen;
   logic [BYTE-1:0]                   charI;
   logic [BYTE-1:0]                   charLen;
   logic [MAX_PAT_ADD-1:0]            fallbackLen;

   // i only reaches the array while i <= last_q, so its low bits suffice as an index.
   assign iIdx        = i_q[MAX_PAT_ADD-1:0];
   assign prevLen     = len_q - 1'b1;
   assign charI       = pat_q[iIdx*BYTE +: BYTE];
   assign charLen     = pat_q[len_q*BYTE +: BYTE];
   assign fallbackLen = ff_q[prevLen*MAX_PAT_ADD +: MAX_PAT_ADD];

   assign busy         = (state_q == INIT) || (state_q == COMP);
   assign output_valid = (state_q == DONE);
   assign ff_result    = ff_q;

   // Next-state logic: capture in INIT, one prefix/suffix comparison per COMP cycle.
   always_comb begin
      state_d = state_q;
      pat_d   = pat_q;
      last_d  = last_q;
      i_d     = i_q;
      len_d   = len_q;
      ff_d    = ff_q;

      case (state_q)
         IDLE: begin
            if (input_valid) begin
               state_d = INIT;
            end
         end

         INIT: begin
            pat_d   = pat_input;
            last_d  = pat_last_idx;
            ff_d    = '0;
            len_d   = '0;
            i_d     = (MAX_PAT_ADD+1)'(1);
            state_d = COMP;
         end

         COMP: begin
            if (!input_valid) begin
               ff_d    = '0;
               state_d = IDLE;
            end else if (i_q > {1'b0, last_q}) begin
               state_d = DONE;
            end else if (charI == charLen) begin
               ff_d[iIdx*MAX_PAT_ADD +: MAX_PAT_ADD] = len_q + 1'b1;
               len_d = len_q + 1'b1;
               i_d   = i_q + 1'b1;
            end else if (len_q != '0) begin
               len_d = fallbackLen;
            end else begin
               ff_d[iIdx*MAX_PAT_ADD +: MAX_PAT_ADD] = '0;
               i_d = i_q + 1'b1;
            end
         end

         DONE: begin
            if (!input_valid) begin
               state_d = IDLE;
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and datapath registers; reset clears everything back to IDLE.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         pat_q   <= '0;
         last_q  <= '0;
         i_q     <= '0;
         len_q   <= '0;
         ff_q    <= '0;
      end else begin
         state_q <= state_d;
         pat_q   <= pat_d;
         last_q  <= last_d;
         i_q     <= i_d;
         len_q   <= len_d;
         ff_q    <= ff_d;
      end
   end

endmodule

// File: tb/tb_kmp_ff_gen.sv
// Directed testbench for kmp_ff_gen with BYTE=8, MAX_PATTERN=8, MAX_PAT_ADD=3.
module tb_kmp_ff_gen;

   localparam int BYTE        = 8;
   localparam int MAX_PATTERN = 8;
   localparam int MAX_PAT_ADD = 3;

   logic                               clk;
   logic                               reset;
   logic [MAX_PATTERN*BYTE-1:0]        pat_input;
   logic [MAX_PAT_ADD-1:0]             pat_last_idx;
   logic                               input_valid;
   logic                               busy;
   logic                               output_valid;
   logic [MAX_PAT_ADD*MAX_PATTERN-1:0] ff_result;

   int passCount  = 0;
   int checkCount = 0;

   kmp_ff_gen #(
      .BYTE(BYTE),
      .MAX_PATTERN(MAX_PATTERN),
      .MAX_PAT_ADD(MAX_PAT_ADD)
   ) dut (
      .clk(clk),
      .reset(reset),
      .pat_input(pat_input),
      .pat_last_idx(pat_last_idx),
      .input_valid(input_valid),
      .busy(busy),
      .output_valid(output_valid),
      .ff_result(ff_result)
   );

   // Free-running clock, rising edges at 5, 15, 25, ...
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Character k of the string goes to bits [k*8 +: 8]; unused characters are zero.
   function automatic logic [MAX_PATTERN*BYTE-1:0] packPat(input string s);
      logic [MAX_PATTERN*BYTE-1:0] p;
      p = '0;
      for (int k = 0; k < s.len(); k++) begin
         p[k*BYTE +: BYTE] = s[k];
      end
      return p;
   endfunction

   // Entry 0 lands in the least significant field.
   function automatic logic [MAX_PAT_ADD*MAX_PATTERN-1:0] packFf(
      input int e0, input int e1, input int e2, input int e3,
      input int e4, input int e5, input int e6, input int e7);
      return {e7[2:0], e6[2:0], e5[2:0], e4[2:0], e3[2:0], e2[2:0], e1[2:0], e0[2:0]};
   endfunction

   // Advance n rising edges and settle 1 time unit past the last one.
   task automatic stepEdges(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Present a new request and raise input_valid; the next rising edge is E0.
   task automatic applyStimulus(input string patStr, input logic [MAX_PAT_ADD-1:0] last);
      pat_input    = packPat(patStr);
      pat_last_idx = last;
      input_valid  = 1'b1;
   endtask

   task automatic checkFlags(input string tag, input logic ovExp, input logic busyExp);
      checkCount++;
      assert (output_valid === ovExp) passCount++;
      else $error("FAIL %s output_valid: got %0b expected %0b", tag, output_valid, ovExp);
      checkCount++;
      assert (busy === busyExp) passCount++;
      else $error("FAIL %s busy: got %0b expected %0b", tag, busy, busyExp);
   endtask

   task automatic checkOutput(input string tag, input logic ovExp, input logic busyExp,
                              input logic [MAX_PAT_ADD*MAX_PATTERN-1:0] ffExp);
      checkFlags(tag, ovExp, busyExp);
      checkCount++;
      assert (ff_result === ffExp) passCount++;
      else $error("FAIL %s ff_result: got %h expected %h", tag, ff_result, ffExp);
   endtask

   // Directed sequence; edge counts derived from E0..E(S+2) with S comparison steps.
   initial begin
      reset        = 1'b1;
      input_valid  = 1'b0;
      pat_input    = '0;
      pat_last_idx = '0;
      stepEdges(2);
      checkOutput("reset", 1'b0, 1'b0, '0);
      reset = 1'b0;
      stepEdges(1);
      checkOutput("idle", 1'b0, 1'b0, '0);

      // "aaaa": S=3, output_valid after E5 (6 edges)
      applyStimulus("aaaa", 3'd3);
      stepEdges(1);
      checkFlags("t1_init", 1'b0, 1'b1);
      stepEdges(4);
      checkFlags("t1_pre", 1'b0, 1'b1);
      stepEdges(1);
      checkOutput("t1_done", 1'b1, 1'b0, packFf(0, 1, 2, 3, 0, 0, 0, 0));
      stepEdges(1);
      checkOutput("t1_hold", 1'b1, 1'b0, packFf(0, 1, 2, 3, 0, 0, 0, 0));
      input_valid = 1'b0;
      stepEdges(1);
      checkOutput("t1_drop", 1'b0, 1'b0, packFf(0, 1, 2, 3, 0, 0, 0, 0));

      // "aabaaab": S=8, output_valid after E10 (11 edges)
      applyStimulus("aabaaab", 3'd6);
      stepEdges(10);
      checkFlags("t2_pre", 1'b0, 1'b1);
      stepEdges(1);
      checkOutput("t2_done", 1'b1, 1'b0, packFf(0, 1, 0, 1, 2, 2, 3, 0));
      input_valid = 1'b0;
      stepEdges(1);
      checkOutput("t2_drop", 1'b0, 1'b0, packFf(0, 1, 0, 1, 2, 2, 3, 0));

      // "abab" with inputs changed during COMP; INIT must also clear entries 4..6
      applyStimulus("abab", 3'd3);
      stepEdges(2);
      pat_input    = packPat("xxxxxxxx");
      pat_last_idx = 3'd7;
      stepEdges(3);
      checkFlags("t6_pre", 1'b0, 1'b1);
      stepEdges(1);
      checkOutput("t6_done", 1'b1, 1'b0, packFf(0, 0, 1, 2, 0, 0, 0, 0));
      input_valid = 1'b0;
      stepEdges(1);

      // "abcd": S=3, all-zero table
      applyStimulus("abcd", 3'd3);
      stepEdges(5);
      checkFlags("t3_pre", 1'b0, 1'b1);
      stepEdges(1);
      checkOutput("t3_done", 1'b1, 1'b0, '0);
      input_valid = 1'b0;
      stepEdges(1);
      checkOutput("t3_drop", 1'b0, 1'b0, '0);

      // Single character: S=0, output_valid after E2 (3 edges)
      applyStimulus("z", 3'd0);
      stepEdges(2);
      checkFlags("t4_pre", 1'b0, 1'b1);
      stepEdges(1);
      checkOutput("t4_done", 1'b1, 1'b0, '0);
      input_valid = 1'b0;
      stepEdges(1);
      applyStimulus("abab", 3'd3);
      stepEdges(5);
      checkFlags("t4b_pre", 1'b0, 1'b1);
      stepEdges(1);
      checkOutput("t4b_done", 1'b1, 1'b0, packFf(0, 0, 1, 2, 0, 0, 0, 0));
      input_valid = 1'b0;
      stepEdges(1);

      // Reset mid-COMP of "aabaaab" (ff1 already written by then)
      applyStimulus("aabaaab", 3'd6);
      stepEdges(5);
      checkOutput("t5_mid", 1'b0, 1'b1, packFf(0, 1, 0, 0, 0, 0, 0, 0));
      reset       = 1'b1;
      input_valid = 1'b0;
      stepEdges(1);
      checkOutput("t5_reset", 1'b0, 1'b0, '0);
      reset = 1'b0;
      stepEdges(1);

      // Abort by dropping input_valid mid-COMP
      applyStimulus("aabaaab", 3'd6);
      stepEdges(5);
      checkOutput("t5b_mid", 1'b0, 1'b1, packFf(0, 1, 0, 0, 0, 0, 0, 0));
      input_valid = 1'b0;
      stepEdges(1);
      checkOutput("t5b_abort", 1'b0, 1'b0, '0);
      stepEdges(2);
      checkOutput("t5b_idle", 1'b0, 1'b0, '0);

      $display("[TB] %0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
